// File: rtl/fifo_stream_rdr.sv
// Drains a registered-read FIFO into a valid/ready stream with a per-burst m_last marker; optional XFER_CNT_EN adds xfer_cnt/cnt_clr.
// Latency: fifo_rd_en in cycle N gives m_valid in N+2, sustaining 1 beat/cycle.
// Backpressure: a 2-entry skid absorbs the read latency; reads stop once buffered plus in-flight words would exceed 2.
module fifo_stream_rdr #(
    parameter int WIDTH     = 64,
    parameter int BURST_LEN = 16,
    parameter int BCNT_W    = $clog2(BURST_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy
`ifdef XFER_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [31:0]      xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BURST_LEN - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_occ;
    logic               r_pend;
    logic [WIDTH-1:0]   r_head;
    logic [WIDTH-1:0]   r_tail;
    logic [BCNT_W-1:0]  r_beat;
    logic               w_pop;
    logic [2:0]         w_level;

    assign w_pop   = m_valid && m_ready;
    // Occupancy after this edge if a read were issued now: pop can only occur with occ>=1, so no underflow.
    assign w_level = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};

    assign fifo_rd_en = (r_state == S_RUN) && enable && !fifo_empty && (w_level < 3'd2);
    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_head;
    assign m_last     = m_valid && (r_beat == LAST_BEAT);
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_state_nxt = S_RUN;
            S_RUN:   if (!enable) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                end else if (!r_pend && (r_occ == 2'd0)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_pend <= fifo_rd_en;
            case ({r_pend, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= fifo_dout;
                    end else begin
                        r_tail <= fifo_dout;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head <= fifo_dout;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    // Beat position survives IDLE/DRAIN so bursts stay aligned across pauses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if (w_pop) begin
            r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
        end
    end

`ifdef XFER_CNT_EN
    logic [31:0] r_xfer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (cnt_clr) begin
            r_xfer_cnt <= '0;
        end else if (w_pop && (r_xfer_cnt != 32'hFFFF_FFFF)) begin
            r_xfer_cnt <= r_xfer_cnt + 32'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule
